// File: rtl/job_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : job_dispatcher_if
//  Purpose  : Bundles the signals between the job dispatcher and its
//             surroundings: the shared memory port, the processor's
//             request/grant memory traffic, the index handshake and status.
//             The master modport is the dispatcher's view. The slave modport
//             is the environment's view (memory + processor + host).
//  Revision : 1.0  initial release
// ============================================================================
interface job_dispatcher_if #(
    parameter int CELL_WIDTH      = 32,
    parameter int INDEX_WIDTH     = 8,
    parameter int WIDTH           = 96,
    parameter int MEMORY_SIZE_LOG = 8
);
    // host control
    logic                       in_start;
    // shared memory port
    logic [WIDTH-1:0]           in_mem_data;
    logic [MEMORY_SIZE_LOG-1:0] out_mem_address;
    logic                       out_mem_read_en;
    logic                       out_mem_write_en;
    logic [WIDTH-1:0]           out_mem_data;
    // processor memory traffic
    logic                       in_proc_request;
    logic [MEMORY_SIZE_LOG-1:0] in_proc_mem_address;
    logic                       in_proc_mem_read_en;
    logic                       in_proc_mem_write_en;
    logic [WIDTH-1:0]           in_proc_mem_data;
    logic                       out_proc_grant;
    // index handshake
    logic [INDEX_WIDTH-1:0]     out_row_index;
    logic [INDEX_WIDTH-1:0]     out_col_index;
    logic                       out_index_ready;
    logic [INDEX_WIDTH-1:0]     out_mu;
    logic [CELL_WIDTH-1:0]      out_config;
    logic                       in_index_ack;
    logic                       in_result_ready;
    // status
    logic                       out_busy;
    logic                       out_done;
    logic [2*INDEX_WIDTH-1:0]   out_job_count;
    logic                       out_error;

    modport master (
        input  in_start, in_mem_data,
        input  in_proc_request, in_proc_mem_address, in_proc_mem_read_en,
        input  in_proc_mem_write_en, in_proc_mem_data,
        input  in_index_ack, in_result_ready,
        output out_mem_address, out_mem_read_en, out_mem_write_en, out_mem_data,
        output out_proc_grant, out_row_index, out_col_index, out_index_ready,
        output out_mu, out_config, out_busy, out_done, out_job_count, out_error
    );

    modport slave (
        output in_start, in_mem_data,
        output in_proc_request, in_proc_mem_address, in_proc_mem_read_en,
        output in_proc_mem_write_en, in_proc_mem_data,
        output in_index_ack, in_result_ready,
        input  out_mem_address, out_mem_read_en, out_mem_write_en, out_mem_data,
        input  out_proc_grant, out_row_index, out_col_index, out_index_ready,
        input  out_mu, out_config, out_busy, out_done, out_job_count, out_error
    );
endinterface
`default_nettype wire

// File: rtl/job_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : job_dispatcher
//  Purpose  : Sequencer around the matrix processor. Fetches the config word
//             (mu/gamma/lambda) from shared memory, walks every (row, col)
//             pair in row-major order through the index handshake, and muxes
//             the single memory port between its own fetch and the processor.
//  Option   : JOB_DISPATCHER_TIMEOUT_EN enables a per-job watchdog
//             (TIMEOUT_CYCLES) that aborts the run and raises out_error.
//  Revision : 1.0  initial release
// ============================================================================
module job_dispatcher #(
    parameter int CELL_WIDTH      = 32,
    parameter int INDEX_WIDTH     = 8,
    parameter int WIDTH           = 96,
    parameter int MEMORY_SIZE_LOG = 8,
    parameter int CONFIG_ADDRESS  = 0
`ifdef JOB_DISPATCHER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 1024
`endif
) (
    input  wire logic        in_clk,
    input  wire logic        in_reset,
    job_dispatcher_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_CHECK   = 3'd3,
        S_ISSUE   = 3'd4,
        S_RELEASE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [INDEX_WIDTH-1:0]   c_IDX_ONE = INDEX_WIDTH'(1);
    localparam logic [2*INDEX_WIDTH-1:0] c_CNT_ONE = (2*INDEX_WIDTH)'(1);

    state_t                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   row_q, row_d;
    logic [INDEX_WIDTH-1:0]   col_q, col_d;
    logic [CELL_WIDTH-1:0]    config_q, config_d;
    logic [2*INDEX_WIDTH-1:0] count_q, count_d;
    logic [INDEX_WIDTH-1:0]   w_gamma;
    logic [INDEX_WIDTH-1:0]   w_lambda;
    logic                     w_grant;

`ifdef JOB_DISPATCHER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               error_q, error_d;
`endif

    // gamma counts columns, lambda counts rows
    assign w_gamma  = config_q[8 +: INDEX_WIDTH];
    assign w_lambda = config_q[0 +: INDEX_WIDTH];
    // the processor owns the memory port exactly while an index is offered
    assign w_grant  = (state_q == S_ISSUE);

    // Next-state and datapath update for the job walk
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        config_d = config_q;
        count_d  = count_q;
`ifdef JOB_DISPATCHER_TIMEOUT_EN
        timer_d  = timer_q;
        error_d  = error_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_start) begin
                    state_d = S_FETCH;
                    count_d = '0;
`ifdef JOB_DISPATCHER_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                // read data arrives one cycle after the FETCH address
                config_d = bus.in_mem_data[CELL_WIDTH-1:0];
                row_d    = '0;
                col_d    = '0;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if ((w_gamma == '0) || (w_lambda == '0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
`ifdef JOB_DISPATCHER_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            S_ISSUE: begin
                if (bus.in_result_ready) begin
                    count_d = count_q + c_CNT_ONE;
                    state_d = S_RELEASE;
                end
`ifdef JOB_DISPATCHER_TIMEOUT_EN
                else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    // abandon the run; the stalled job is not counted
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
`endif
            end
            S_RELEASE: begin
                if (col_q != (w_gamma - c_IDX_ONE)) begin
                    col_d   = col_q + c_IDX_ONE;
                    state_d = S_ISSUE;
                end else if (row_q != (w_lambda - c_IDX_ONE)) begin
                    col_d   = '0;
                    row_d   = row_q + c_IDX_ONE;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
`ifdef JOB_DISPATCHER_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; active-low synchronous reset aborts any run
    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            config_q <= '0;
            count_q  <= '0;
`ifdef JOB_DISPATCHER_TIMEOUT_EN
            timer_q  <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            config_q <= config_d;
            count_q  <= count_d;
`ifdef JOB_DISPATCHER_TIMEOUT_EN
            timer_q  <= timer_d;
            error_q  <= error_d;
`endif
        end
    end

    // Memory port mux: processor when granted, otherwise our own config fetch
    always_comb begin
        bus.out_mem_address  = '0;
        bus.out_mem_read_en  = 1'b0;
        bus.out_mem_write_en = 1'b0;
        bus.out_mem_data     = '0;
        if (w_grant) begin
            bus.out_mem_address  = bus.in_proc_mem_address;
            bus.out_mem_read_en  = bus.in_proc_mem_read_en;
            bus.out_mem_write_en = bus.in_proc_mem_write_en;
            bus.out_mem_data     = bus.in_proc_mem_data;
        end else if (state_q == S_FETCH) begin
            bus.out_mem_address  = MEMORY_SIZE_LOG'(CONFIG_ADDRESS);
            bus.out_mem_read_en  = 1'b1;
        end
    end

    assign bus.out_proc_grant  = w_grant;
    assign bus.out_index_ready = w_grant;
    assign bus.out_row_index   = row_q;
    assign bus.out_col_index   = col_q;
    assign bus.out_mu          = config_q[16 +: INDEX_WIDTH];
    assign bus.out_config      = config_q;
    assign bus.out_busy        = (state_q != S_IDLE);
    assign bus.out_done        = (state_q == S_DONE);
    assign bus.out_job_count   = count_q;
`ifdef JOB_DISPATCHER_TIMEOUT_EN
    assign bus.out_error       = error_q;
`else
    assign bus.out_error       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_job_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_job_dispatcher
//  Purpose  : Self-checking bench for job_dispatcher. A timeline model derived
//             from the job rules (fixed fetch latency, row-major pair queue,
//             one release cycle per job, done after the last release) is
//             compared against the DUT every cycle; directed scenarios add
//             literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_job_dispatcher;

    localparam int CW       = 32;
    localparam int IW       = 8;
    localparam int W        = 96;
    localparam int ML       = 8;
    localparam int CFG_ADDR = 0;
    localparam int TO       = 16;
    localparam int RR_DELAY = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] c;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    job_dispatcher_if #(.CELL_WIDTH(CW), .INDEX_WIDTH(IW), .WIDTH(W), .MEMORY_SIZE_LOG(ML)) bus ();

    job_dispatcher #(
        .CELL_WIDTH(CW), .INDEX_WIDTH(IW), .WIDTH(W), .MEMORY_SIZE_LOG(ML),
        .CONFIG_ADDRESS(CFG_ADDR)
`ifdef JOB_DISPATCHER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .in_clk  (clk),
        .in_reset(rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit rr_en = 1'b1;

    logic [W-1:0] mem [0:255];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory: one-cycle registered read ----------------
    initial begin
        logic         rd_v;
        logic [ML-1:0] rd_a;
        bus.in_mem_data = '0;
        forever begin
            @(negedge clk);
            rd_v = bus.out_mem_read_en;
            rd_a = bus.out_mem_address;
            @(posedge clk);
            #1;
            if (rd_v === 1'b1) bus.in_mem_data = mem[rd_a];
        end
    end

    // ---------------- processor: result_ready on the 4th index cycle ----
    initial begin
        int ir_cnt;
        ir_cnt = 0;
        bus.in_result_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.out_index_ready === 1'b1 && rr_en) begin
                ir_cnt++;
                bus.in_result_ready = (ir_cnt >= RR_DELAY);
            end else begin
                ir_cnt = 0;
                bus.in_result_ready = 1'b0;
            end
        end
    end

    // ---------------- timeline model + per-cycle compare ----------------
    pair_t       exp_q[$];
    pair_t       acc_log[$];
    bit          m_run = 0;
    int          m_t = 0;
    int          m_total = 0;
    int          m_count = 0;
    int          m_after = 0;
    bit          m_rel = 0;
    bit          m_to = 0;
    bit          m_err = 0;
    int          m_iss = 0;
    logic [31:0] m_cfg = '0;
    logic [31:0] m_ncfg = '0;

    always @(negedge clk) begin : cmp
        bit    e_ir;
        bit    e_done;
        bit    e_fetch;
        pair_t p;
        int    lam;
        int    gam;
        e_ir    = m_run && (m_t >= 4) && !m_rel && !m_to && (exp_q.size() > 0);
        e_done  = m_run && (m_to || (m_total == 0 && m_t == 4) ||
                            (m_total > 0 && exp_q.size() == 0 && m_after == 2));
        e_fetch = m_run && (m_t == 1);
        if (chk_en) begin
            chk("busy", bus.out_busy, m_run);
            chk("index_ready", bus.out_index_ready, e_ir);
            chk("grant", bus.out_proc_grant, e_ir);
            chk("done", bus.out_done, e_done);
            chk("job_count", bus.out_job_count, m_count);
            chk("config", bus.out_config, m_cfg);
            chk("mu", bus.out_mu, m_cfg[23:16]);
            chk("error", bus.out_error, m_err);
            if (e_ir) begin
                chk("row", bus.out_row_index, exp_q[0].r);
                chk("col", bus.out_col_index, exp_q[0].c);
                chk("mux_addr", bus.out_mem_address, bus.in_proc_mem_address);
                chk("mux_rd", bus.out_mem_read_en, bus.in_proc_mem_read_en);
                chk("mux_wr", bus.out_mem_write_en, bus.in_proc_mem_write_en);
                chk("mux_data", bus.out_mem_data, bus.in_proc_mem_data);
            end else begin
                chk("own_addr", bus.out_mem_address, e_fetch ? CFG_ADDR : 0);
                chk("own_rd", bus.out_mem_read_en, e_fetch);
                chk("own_wr", bus.out_mem_write_en, 1'b0);
                chk("own_data", bus.out_mem_data, '0);
            end
        end
        // advance the model to the next cycle
        if (rst_n !== 1'b1) begin
            m_run = 0; m_t = 0; m_total = 0; m_count = 0; m_after = 0;
            m_rel = 0; m_to = 0; m_err = 0; m_iss = 0; m_cfg = '0;
            exp_q.delete();
        end else if (!m_run) begin
            if (bus.in_start === 1'b1) begin
                m_run = 1; m_t = 1; m_count = 0; m_after = 0; m_rel = 0;
                m_to = 0; m_err = 0; m_iss = 0;
                m_ncfg = mem[CFG_ADDR][31:0];
                lam = int'(m_ncfg[7:0]);
                gam = int'(m_ncfg[15:8]);
                m_total = lam * gam;
                exp_q.delete();
                for (int r = 0; r < lam; r++) begin
                    for (int c = 0; c < gam; c++) begin
                        p.r = 8'(r);
                        p.c = 8'(c);
                        exp_q.push_back(p);
                    end
                end
            end
        end else if (e_done) begin
            m_run = 0;
        end else begin
            m_t++;
            if (m_t == 3) m_cfg = m_ncfg;
            m_rel = 0;
            if (m_after > 0) m_after++;
            if (e_ir) begin
                if (bus.in_result_ready === 1'b1) begin
                    acc_log.push_back(exp_q.pop_front());
                    m_count++;
                    m_rel = 1;
                    m_iss = 0;
                    if (exp_q.size() == 0) m_after = 1;
                end else begin
                    m_iss++;
`ifdef JOB_DISPATCHER_TIMEOUT_EN
                    if (m_iss == TO) begin
                        m_to  = 1;
                        m_err = 1;
                    end
`endif
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    int done_pulses;
    int done_at;
    int busy_fall;
    int ir_cycles;
    int job_seen;

    // mode 0: plain run; 1: processor traffic + stray start; 2: reset at job 3
    task automatic run(input int mode, input int budget);
        bit prev_ir;
        bit seen_done;
        bit chk_rd;
        bit chk_wr;
        int rst_phase;
        bit rst_checked;
        done_pulses = 0; done_at = -1; busy_fall = -1; ir_cycles = 0; job_seen = 0;
        prev_ir = 0; seen_done = 0; chk_rd = 0; chk_wr = 0; rst_phase = 0; rst_checked = 0;
        @(posedge clk);
        #1;
        bus.in_start = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (chk_rd) begin
                chk("proc_read_addr", bus.out_mem_address, 8'h12);
                chk("proc_read_en", bus.out_mem_read_en, 1'b1);
                chk_rd = 0;
            end
            if (chk_wr) begin
                chk("release_write_blocked", bus.out_mem_write_en, 1'b0);
                chk("release_grant", bus.out_proc_grant, 1'b0);
                chk_wr = 0;
            end
            if (rst_phase == 2) begin
                chk("rst_busy", bus.out_busy, 1'b0);
                chk("rst_done", bus.out_done, 1'b0);
                chk("rst_ready", bus.out_index_ready, 1'b0);
                chk("rst_grant", bus.out_proc_grant, 1'b0);
                chk("rst_row", bus.out_row_index, 8'd0);
                chk("rst_col", bus.out_col_index, 8'd0);
                chk("rst_mu", bus.out_mu, 8'd0);
                chk("rst_config", bus.out_config, 32'd0);
                chk("rst_count", bus.out_job_count, 16'd0);
                chk("rst_rd_en", bus.out_mem_read_en, 1'b0);
                chk("rst_wr_en", bus.out_mem_write_en, 1'b0);
                rst_checked = 1;
                break;
            end
            if (seen_done) begin
                if (bus.out_busy === 1'b0) busy_fall = c;
                break;
            end
            if (bus.out_done === 1'b1) begin
                done_pulses++;
                done_at = c;
                seen_done = 1;
            end
            @(posedge clk);
            #1;
            bus.in_start             = 1'b0;
            bus.in_proc_mem_read_en  = 1'b0;
            bus.in_proc_mem_write_en = 1'b0;
            bus.in_proc_mem_address  = '0;
            bus.in_proc_mem_data     = '0;
            bus.in_index_ack         = bus.out_index_ready;
            bus.in_proc_request      = bus.out_index_ready;
            if (rst_phase == 1) begin
                rst_n = 1'b1;
                rst_phase = 2;
            end
            if (bus.out_index_ready === 1'b1) ir_cycles++;
            if (bus.out_index_ready === 1'b1 && !prev_ir) begin
                job_seen++;
                if (mode == 1 && job_seen == 2) begin
                    bus.in_proc_mem_address = 8'h12;
                    bus.in_proc_mem_read_en = 1'b1;
                    chk_rd = 1;
                end
                if (mode == 1 && job_seen == 4) bus.in_start = 1'b1;
                if (mode == 2 && job_seen == 3) begin
                    rst_n = 1'b0;
                    rst_phase = 1;
                end
            end
            if (mode == 1 && prev_ir && bus.out_index_ready === 1'b0 && job_seen == 2) begin
                bus.in_proc_mem_address  = 8'h34;
                bus.in_proc_mem_write_en = 1'b1;
                bus.in_proc_mem_data     = 96'hA5A5;
                chk_wr = 1;
            end
            prev_ir = (bus.out_index_ready === 1'b1);
        end
        if (mode == 2) chk("reset_reached", rst_checked, 1'b1);
        else           chk("done_reached", seen_done, 1'b1);
    endtask

    initial begin
        pair_t lit [6];
        pair_t got;
        lit[0] = {8'd0, 8'd0}; lit[1] = {8'd0, 8'd1}; lit[2] = {8'd1, 8'd0};
        lit[3] = {8'd1, 8'd1}; lit[4] = {8'd2, 8'd0}; lit[5] = {8'd2, 8'd1};

        bus.in_start = 1'b0; bus.in_index_ack = 1'b0; bus.in_proc_request = 1'b0;
        bus.in_proc_mem_address = '0; bus.in_proc_mem_read_en = 1'b0;
        bus.in_proc_mem_write_en = 1'b0; bus.in_proc_mem_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h12] = 96'h0123_4567_89AB_CDEF_1122_3344;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", bus.out_busy, 1'b0);
        chk("reset_count", bus.out_job_count, 16'd0);
        chk("reset_config", bus.out_config, 32'd0);

        // 3 rows x 2 cols, with processor traffic and a stray start
        mem[CFG_ADDR] = 96'h0002_0203;
        acc_log.delete();
        run(1, 300);
        chk("t1_jobs_len", acc_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            got = (i < acc_log.size()) ? acc_log[i] : 16'hFFFF;
            chk($sformatf("t1_order%0d", i), got, lit[i]);
        end
        chk("t1_mu", bus.out_mu, 8'd2);
        chk("t1_count", bus.out_job_count, 16'd6);
        chk("t1_done_pulses", done_pulses, 1);
        chk("t1_busy_fall", busy_fall, done_at + 1);
        chk("t1_config", bus.out_config, 32'h0002_0203);

        // gamma = 0: straight from CHECK to DONE
        mem[CFG_ADDR] = 96'h0005_0003;
        run(0, 100);
        chk("t2_done_latency", done_at, 4);
        chk("t2_no_index", ir_cycles, 0);
        chk("t2_count", bus.out_job_count, 16'd0);
        chk("t2_mu", bus.out_mu, 8'd5);

        // reset during the third job, then a clean rerun
        mem[CFG_ADDR] = 96'h0002_0203;
        run(2, 300);
        acc_log.delete();
        run(0, 300);
        chk("t3_jobs_len", acc_log.size(), 6);
        got = (acc_log.size() > 0) ? acc_log[0] : 16'hFFFF;
        chk("t3_first_pair", got, 16'h0000);
        chk("t3_count", bus.out_job_count, 16'd6);
        chk("t3_done_pulses", done_pulses, 1);

`ifdef JOB_DISPATCHER_TIMEOUT_EN
        // processor never answers: watchdog after TO issue cycles
        rr_en = 1'b0;
        run(0, 300);
        chk("t4_issue_cycles", ir_cycles, TO);
        chk("t4_error", bus.out_error, 1'b1);
        chk("t4_count", bus.out_job_count, 16'd0);
        chk("t4_done_pulses", done_pulses, 1);
        rr_en = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
